// File: rtl/ip_packet_rx.sv
// Byte-serial Ethernet II / IPv4 receive filter: parses headers from the MAC RX stream,
// drops frames that fail any check, and hands accepted sender/message fields to the accelerator.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  RECV  | consuming bytes (READY=1), parsing and checking until LAST
//  HOLD  | accepted result presented on RX_VALID, stream stalled (READY=0)
module ip_packet_rx #(
    parameter logic [7:0]  IP_PROTOCOL     = 8'h04,
    parameter int unsigned MIN_FRAME_BYTES = 36
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] ACCELERATOR_IP_ADDRESS,
    input  logic [47:0] ACCELERATOR_MAC_ADDRESS,
    input  logic [7:0]  MAC_DATA_IN,
    input  logic        MAC_DATA_VALID,
    output logic        MAC_DATA_READY,
    input  logic        MAC_DATA_LAST,
    input  logic        MAC_DATA_TUSER,
    output logic [47:0] SENDER_MAC_ADDRESS,
    output logic [31:0] SENDER_IP_ADDRESS,
    output logic [9:0]  RECEIVED_MESSAGE,
    output logic        RX_VALID,
    input  logic        RX_ACCEPT,
    output logic [15:0] DROP_COUNT
);

    typedef enum logic {S_RECV, S_HOLD} state_t;

    localparam logic [11:0] MIN_BYTES = 12'(MIN_FRAME_BYTES);

    state_t      state_q, state_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic        bad_q, bad_d;
    logic [19:0] csum_q, csum_d;
    logic [7:0]  prev_byte_q, prev_byte_d;
    logic        mac_uc_q, mac_uc_d;
    logic        mac_bc_q, mac_bc_d;
    logic [47:0] src_mac_stage_q, src_mac_stage_d;
    logic [31:0] src_ip_stage_q, src_ip_stage_d;
    logic [9:0]  msg_stage_q, msg_stage_d;
    logic [47:0] sender_mac_q, sender_mac_d;
    logic [31:0] sender_ip_q, sender_ip_d;
    logic [9:0]  message_q, message_d;
    logic        rx_valid_q, rx_valid_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic        beat;
    logic        field_fail;
    logic        frame_bad;
    logic        uc_so_far, bc_so_far, uc_now, bc_now;
    logic [7:0]  local_mac_byte;
    logic [7:0]  local_ip_byte;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic        csum_ok;
    logic        too_short;

    assign MAC_DATA_READY     = (state_q == S_RECV);
    assign beat               = MAC_DATA_VALID & MAC_DATA_READY;
    assign SENDER_MAC_ADDRESS = sender_mac_q;
    assign SENDER_IP_ADDRESS  = sender_ip_q;
    assign RECEIVED_MESSAGE   = message_q;
    assign RX_VALID           = rx_valid_q;
    assign DROP_COUNT         = drop_cnt_q;

    // Ones'-complement check: carries can exceed one fold, so fold twice.
    assign fold1     = {1'b0, csum_q[15:0]} + {13'd0, csum_q[19:16]};
    assign fold2     = fold1[15:0] + {15'd0, fold1[16]};
    assign csum_ok   = (fold2 == 16'hFFFF);
    assign too_short = (({1'b0, byte_cnt_q} + 12'd1) < MIN_BYTES);

    always_comb begin
        local_mac_byte = 8'h00;
        local_ip_byte  = 8'h00;
        case (byte_cnt_q)
            11'd0:   local_mac_byte = ACCELERATOR_MAC_ADDRESS[47:40];
            11'd1:   local_mac_byte = ACCELERATOR_MAC_ADDRESS[39:32];
            11'd2:   local_mac_byte = ACCELERATOR_MAC_ADDRESS[31:24];
            11'd3:   local_mac_byte = ACCELERATOR_MAC_ADDRESS[23:16];
            11'd4:   local_mac_byte = ACCELERATOR_MAC_ADDRESS[15:8];
            11'd5:   local_mac_byte = ACCELERATOR_MAC_ADDRESS[7:0];
            11'd30:  local_ip_byte  = ACCELERATOR_IP_ADDRESS[31:24];
            11'd31:  local_ip_byte  = ACCELERATOR_IP_ADDRESS[23:16];
            11'd32:  local_ip_byte  = ACCELERATOR_IP_ADDRESS[15:8];
            11'd33:  local_ip_byte  = ACCELERATOR_IP_ADDRESS[7:0];
            default: ;
        endcase
    end

    // Destination MAC: track unicast and broadcast match in parallel, decide on byte 5.
    assign uc_so_far = (byte_cnt_q == 11'd0) ? 1'b1 : mac_uc_q;
    assign bc_so_far = (byte_cnt_q == 11'd0) ? 1'b1 : mac_bc_q;
    assign uc_now    = uc_so_far & (MAC_DATA_IN == local_mac_byte);
    assign bc_now    = bc_so_far & (MAC_DATA_IN == 8'hFF);

    always_comb begin
        state_d         = state_q;
        byte_cnt_d      = byte_cnt_q;
        bad_d           = bad_q;
        csum_d          = csum_q;
        prev_byte_d     = prev_byte_q;
        mac_uc_d        = mac_uc_q;
        mac_bc_d        = mac_bc_q;
        src_mac_stage_d = src_mac_stage_q;
        src_ip_stage_d  = src_ip_stage_q;
        msg_stage_d     = msg_stage_q;
        sender_mac_d    = sender_mac_q;
        sender_ip_d     = sender_ip_q;
        message_d       = message_q;
        rx_valid_d      = rx_valid_q;
        drop_cnt_d      = drop_cnt_q;
        field_fail      = 1'b0;
        frame_bad       = 1'b0;

        case (state_q)
            S_RECV: begin
                if (beat) begin
                    prev_byte_d = MAC_DATA_IN;

                    if (byte_cnt_q <= 11'd5) begin
                        mac_uc_d = uc_now;
                        mac_bc_d = bc_now;
                        if (byte_cnt_q == 11'd5 && !(uc_now || bc_now))
                            field_fail = 1'b1;
                    end
                    if (byte_cnt_q >= 11'd6 && byte_cnt_q <= 11'd11)
                        src_mac_stage_d = {src_mac_stage_q[39:0], MAC_DATA_IN};
                    if (byte_cnt_q == 11'd12 && MAC_DATA_IN != 8'h08)
                        field_fail = 1'b1;
                    if (byte_cnt_q == 11'd13 && MAC_DATA_IN != 8'h00)
                        field_fail = 1'b1;
                    if (byte_cnt_q == 11'd14 && MAC_DATA_IN != 8'h45)
                        field_fail = 1'b1;
                    if (byte_cnt_q == 11'd17 && {prev_byte_q, MAC_DATA_IN} < 16'd22)
                        field_fail = 1'b1;
                    if (byte_cnt_q == 11'd23 && MAC_DATA_IN != IP_PROTOCOL)
                        field_fail = 1'b1;
                    if (byte_cnt_q >= 11'd26 && byte_cnt_q <= 11'd29)
                        src_ip_stage_d = {src_ip_stage_q[23:0], MAC_DATA_IN};
                    if (byte_cnt_q >= 11'd30 && byte_cnt_q <= 11'd33 &&
                        MAC_DATA_IN != local_ip_byte)
                        field_fail = 1'b1;
                    if (byte_cnt_q == 11'd34)
                        msg_stage_d[9:8] = MAC_DATA_IN[1:0];
                    if (byte_cnt_q == 11'd35)
                        msg_stage_d[7:0] = MAC_DATA_IN;

                    if (byte_cnt_q[0] && byte_cnt_q >= 11'd15 && byte_cnt_q <= 11'd33)
                        csum_d = csum_q + {4'h0, prev_byte_q, MAC_DATA_IN};

                    bad_d = bad_q | field_fail;

                    if (MAC_DATA_LAST) begin
                        byte_cnt_d = 11'd0;
                        bad_d      = 1'b0;
                        csum_d     = 20'd0;
                        frame_bad  = bad_q | field_fail | ~csum_ok |
                                     MAC_DATA_TUSER | too_short;
                        if (frame_bad) begin
                            if (drop_cnt_q != 16'hFFFF)
                                drop_cnt_d = drop_cnt_q + 16'd1;
                        end else begin
                            sender_mac_d = src_mac_stage_d;
                            sender_ip_d  = src_ip_stage_d;
                            message_d    = msg_stage_d;
                            rx_valid_d   = 1'b1;
                            state_d      = S_HOLD;
                        end
                    end else if (byte_cnt_q != 11'h7FF) begin
                        byte_cnt_d = byte_cnt_q + 11'd1;
                    end
                end
            end
            S_HOLD: begin
                if (rx_valid_q && RX_ACCEPT) begin
                    rx_valid_d = 1'b0;
                    state_d    = S_RECV;
                end
            end
            default: state_d = S_RECV;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q         <= S_RECV;
            byte_cnt_q      <= 11'd0;
            bad_q           <= 1'b0;
            csum_q          <= 20'd0;
            prev_byte_q     <= 8'h00;
            mac_uc_q        <= 1'b0;
            mac_bc_q        <= 1'b0;
            src_mac_stage_q <= 48'd0;
            src_ip_stage_q  <= 32'd0;
            msg_stage_q     <= 10'd0;
            sender_mac_q    <= 48'd0;
            sender_ip_q     <= 32'd0;
            message_q       <= 10'd0;
            rx_valid_q      <= 1'b0;
            drop_cnt_q      <= 16'd0;
        end else begin
            state_q         <= state_d;
            byte_cnt_q      <= byte_cnt_d;
            bad_q           <= bad_d;
            csum_q          <= csum_d;
            prev_byte_q     <= prev_byte_d;
            mac_uc_q        <= mac_uc_d;
            mac_bc_q        <= mac_bc_d;
            src_mac_stage_q <= src_mac_stage_d;
            src_ip_stage_q  <= src_ip_stage_d;
            msg_stage_q     <= msg_stage_d;
            sender_mac_q    <= sender_mac_d;
            sender_ip_q     <= sender_ip_d;
            message_q       <= message_d;
            rx_valid_q      <= rx_valid_d;
            drop_cnt_q      <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_ip_packet_rx.sv
// Directed bench for ip_packet_rx: good, gapped, rejected, broadcast, reset and back-to-back frames.
module tb_ip_packet_rx;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] ACCELERATOR_IP_ADDRESS  = 32'hBEEFBEEF;
    logic [47:0] ACCELERATOR_MAC_ADDRESS = 48'h54B00BEDABBA;
    logic [7:0]  MAC_DATA_IN;
    logic        MAC_DATA_VALID;
    logic        MAC_DATA_READY;
    logic        MAC_DATA_LAST;
    logic        MAC_DATA_TUSER;
    logic [47:0] SENDER_MAC_ADDRESS;
    logic [31:0] SENDER_IP_ADDRESS;
    logic [9:0]  RECEIVED_MESSAGE;
    logic        RX_VALID;
    logic        RX_ACCEPT;
    logic [15:0] DROP_COUNT;

    int n_checks = 0;
    int n_errors = 0;
    int vcount   = 0;
    int v0;

    logic [7:0] frm [0:63];
    int         gap [0:63];

    ip_packet_rx dut (
        .ACLK                    (ACLK),
        .ARESET                  (ARESET),
        .ACCELERATOR_IP_ADDRESS  (ACCELERATOR_IP_ADDRESS),
        .ACCELERATOR_MAC_ADDRESS (ACCELERATOR_MAC_ADDRESS),
        .MAC_DATA_IN             (MAC_DATA_IN),
        .MAC_DATA_VALID          (MAC_DATA_VALID),
        .MAC_DATA_READY          (MAC_DATA_READY),
        .MAC_DATA_LAST           (MAC_DATA_LAST),
        .MAC_DATA_TUSER          (MAC_DATA_TUSER),
        .SENDER_MAC_ADDRESS      (SENDER_MAC_ADDRESS),
        .SENDER_IP_ADDRESS       (SENDER_IP_ADDRESS),
        .RECEIVED_MESSAGE        (RECEIVED_MESSAGE),
        .RX_VALID                (RX_VALID),
        .RX_ACCEPT               (RX_ACCEPT),
        .DROP_COUNT              (DROP_COUNT)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) if (RX_VALID) vcount++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_good();
        logic [7:0] hdr [0:35];
        hdr = '{8'h54, 8'hB0, 8'h0B, 8'hED, 8'hAB, 8'hBA,
                8'h32, 8'hDA, 8'hBB, 8'hAD, 8'hEB, 8'hD5,
                8'h08, 8'h00,
                8'h45, 8'h00, 8'h00, 8'h16, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h80, 8'h04, 8'h1F, 8'h68,
                8'hDE, 8'hAD, 8'hBE, 8'hEF,
                8'hBE, 8'hEF, 8'hBE, 8'hEF,
                8'h01, 8'hFF};
        for (int i = 0; i < 64; i++) begin
            frm[i] = (i < 36) ? hdr[i] : 8'h00;
            gap[i] = 0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the final beat.
    task automatic send_frame(input int len, input bit with_last, input bit tuser);
        int waited;
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                MAC_DATA_VALID = 1'b0;
                @(negedge ACLK);
            end
            MAC_DATA_IN    = frm[i];
            MAC_DATA_VALID = 1'b1;
            MAC_DATA_LAST  = with_last && (i == len - 1);
            MAC_DATA_TUSER = tuser && with_last && (i == len - 1);
            waited = 0;
            while (!MAC_DATA_READY && waited < 50) begin
                @(negedge ACLK);
                waited++;
            end
            if (waited >= 50) check("ready_timeout", 64'(waited), 64'(0));
            @(negedge ACLK);
        end
        MAC_DATA_VALID = 1'b0;
        MAC_DATA_LAST  = 1'b0;
        MAC_DATA_TUSER = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [15:0] drops);
        check({tag, "_valid"}, 64'(RX_VALID), 64'(1));
        check({tag, "_ready"}, 64'(MAC_DATA_READY), 64'(0));
        check({tag, "_smac"},  64'(SENDER_MAC_ADDRESS), 64'h32DABBADEBD5);
        check({tag, "_sip"},   64'(SENDER_IP_ADDRESS), 64'hDEADBEEF);
        check({tag, "_msg"},   64'(RECEIVED_MESSAGE), 64'h1FF);
        check({tag, "_drops"}, 64'(DROP_COUNT), 64'(drops));
    endtask

    task automatic accept_result(input string tag);
        RX_ACCEPT = 1'b1;
        @(negedge ACLK);
        RX_ACCEPT = 1'b0;
        check({tag, "_acc_valid"}, 64'(RX_VALID), 64'(0));
        check({tag, "_acc_ready"}, 64'(MAC_DATA_READY), 64'(1));
        check({tag, "_acc_smac"},  64'(SENDER_MAC_ADDRESS), 64'h32DABBADEBD5);
    endtask

    task automatic check_reject(input string tag, input logic [15:0] drops);
        check({tag, "_valid"}, 64'(RX_VALID), 64'(0));
        check({tag, "_ready"}, 64'(MAC_DATA_READY), 64'(1));
        check({tag, "_drops"}, 64'(DROP_COUNT), 64'(drops));
    endtask

    initial begin
        ARESET         = 1'b1;
        MAC_DATA_IN    = 8'h00;
        MAC_DATA_VALID = 1'b0;
        MAC_DATA_LAST  = 1'b0;
        MAC_DATA_TUSER = 1'b0;
        RX_ACCEPT      = 1'b0;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);

        check("rst_ready", 64'(MAC_DATA_READY), 64'(1));
        check("rst_valid", 64'(RX_VALID), 64'(0));
        check("rst_drops", 64'(DROP_COUNT), 64'(0));
        check("rst_smac",  64'(SENDER_MAC_ADDRESS), 64'(0));
        check("rst_sip",   64'(SENDER_IP_ADDRESS), 64'(0));
        check("rst_msg",   64'(RECEIVED_MESSAGE), 64'(0));

        // Good frame, contiguous, held for 5 cycles before accept
        build_good();
        send_frame(64, 1'b1, 1'b0);
        check_result("good", 16'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            check_result("hold", 16'd0);
        end
        accept_result("good");

        // Same frame with valid gaps
        build_good();
        gap[4]  = 1;
        gap[20] = 3;
        gap[33] = 6;
        send_frame(64, 1'b1, 1'b0);
        check_result("gaps", 16'd0);
        accept_result("gaps");

        // Rejections
        build_good();
        frm[25] = 8'h69;
        send_frame(64, 1'b1, 1'b0);
        check_reject("bad_csum", 16'd1);

        build_good();
        frm[30] = 8'hDE; frm[31] = 8'hAD; frm[32] = 8'hBE; frm[33] = 8'hEE;
        send_frame(64, 1'b1, 1'b0);
        check_reject("bad_dstip", 16'd2);

        build_good();
        frm[5] = 8'hBB;
        send_frame(64, 1'b1, 1'b0);
        check_reject("bad_dstmac", 16'd3);

        build_good();
        send_frame(64, 1'b1, 1'b1);
        check_reject("tuser", 16'd4);

        build_good();
        send_frame(31, 1'b1, 1'b0);
        check_reject("short", 16'd5);

        // Broadcast destination
        build_good();
        for (int i = 0; i < 6; i++) frm[i] = 8'hFF;
        send_frame(64, 1'b1, 1'b0);
        check_result("bcast", 16'd5);
        accept_result("bcast");

        // Reset mid-frame, then a complete good frame
        build_good();
        send_frame(20, 1'b0, 1'b0);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("midrst_valid", 64'(RX_VALID), 64'(0));
        check("midrst_drops", 64'(DROP_COUNT), 64'(0));
        send_frame(64, 1'b1, 1'b0);
        check_result("after_rst", 16'd0);
        accept_result("after_rst");

        // Back-to-back with accept tied high
        RX_ACCEPT = 1'b1;
        v0 = vcount;
        build_good();
        send_frame(64, 1'b1, 1'b0);
        check("b2b1_valid", 64'(RX_VALID), 64'(1));
        check("b2b1_ready", 64'(MAC_DATA_READY), 64'(0));
        send_frame(64, 1'b1, 1'b0);
        check("b2b2_valid", 64'(RX_VALID), 64'(1));
        check("b2b2_msg",   64'(RECEIVED_MESSAGE), 64'h1FF);
        @(negedge ACLK);
        check("b2b2_clear", 64'(RX_VALID), 64'(0));
        @(negedge ACLK);
        check("b2b_pulses", 64'(vcount - v0), 64'(2));
        check("b2b_drops",  64'(DROP_COUNT), 64'(0));
        RX_ACCEPT = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
